// File: rtl/fifo_serial_tx.sv
// Show-ahead FIFO consumer that serialises words onto a one-wire bus (start, LSB-first data, stop).
// Define FIFO_SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_serial_tx #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_deq,
  input  logic             bus_grant,
  output logic             bus_req,
  output logic             tx_line,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef FIFO_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, START, DATA, STOP} state_t;
`endif

  state_t             state_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [BIT_W-1:0]   bit_q;
  logic [WIDTH-1:0]   shift_q;
  logic               tx_q;
  logic               req_q;
  logic               deq_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic               parity_q;
`endif

  // Loading a word (from REQ or straight out of STOP) pops the FIFO and drives the start bit at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      req_q    <= 1'b0;
      deq_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      deq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (fifo_empty) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus_grant) begin
            shift_q  <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q <= ^fifo_data;
`endif
            deq_q    <= 1'b1;
            state_q  <= START;
            tx_q     <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            cnt_q  <= cnt_q + CNT_W'(1);
            // Grant is only re-examined here, so a mid-frame drop never truncates a frame.
            if (bus_grant && !fifo_empty) begin
              shift_q  <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
              parity_q <= ^fifo_data;
`endif
              deq_q    <= 1'b1;
              state_q  <= START;
              tx_q     <= 1'b0;
              bit_q    <= '0;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_deq   = deq_q;
  assign bus_req    = req_q;
  assign tx_line    = tx_q;
  assign busy       = busy_q;
  assign words_sent = cnt_q;

endmodule
